// File: rtl/tone_player.sv
// tone_player: renders a latched 4-bit tone index as a square wave.
//   Index 0..9 plays one note of a fixed 10-note scale, 10..15 is a silent rest.
//   Each accepted start plays for DURATION_MS milliseconds, then pulses done.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        request strobe, sampled only while idle
//   tone         tone index, latched when start is accepted
//   stop         synchronous abort (highest priority after reset)
//   mute         forces sound_out low; timing continues
//   sound_out    square-wave audio output
//   busy         high while a tone or rest is in progress
//   done         one-cycle pulse on normal completion
//   tone_playing index latched at the last accepted start
module tone_player #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DURATION_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] tone,
  input  logic       stop,
  input  logic       mute,
  output logic       sound_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] tone_playing
);

  localparam int unsigned TICKS_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [9:0]    MS_LAST  = 10'(DURATION_MS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, REST} state_t;

  state_t        state;
  logic [23:0]   half_cnt;
  logic          wave;
  logic [PW-1:0] prescale;
  logic [9:0]    ms_cnt;

  // Half-period in clock cycles for each note; rests get a harmless 1.
  function automatic logic [23:0] half_of(input logic [3:0] idx);
    int unsigned f;
    case (idx)
      4'd0:    f = 262;
      4'd1:    f = 294;
      4'd2:    f = 330;
      4'd3:    f = 349;
      4'd4:    f = 392;
      4'd5:    f = 440;
      4'd6:    f = 494;
      4'd7:    f = 523;
      4'd8:    f = 587;
      4'd9:    f = 659;
      default: f = 0;
    endcase
    if (f == 0) return 24'd1;
    return 24'(CLK_FREQ_HZ / (2 * f));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      half_cnt     <= '0;
      wave         <= 1'b0;
      prescale     <= '0;
      ms_cnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tone_playing <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        busy     <= 1'b0;
        wave     <= 1'b0;
        half_cnt <= '0;
        prescale <= '0;
        ms_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              tone_playing <= tone;
              state        <= (tone <= 4'd9) ? PLAY : REST;
              busy         <= 1'b1;
              half_cnt     <= half_of(tone) - 24'd1;
              prescale     <= '0;
              ms_cnt       <= '0;
              wave         <= 1'b0;
            end
          end
          PLAY, REST: begin
            if (state == PLAY) begin
              if (half_cnt == '0) begin
                wave     <= ~wave;
                half_cnt <= half_of(tone_playing) - 24'd1;
              end else begin
                half_cnt <= half_cnt - 24'd1;
              end
            end
            // Completion is detected on the wrap that would take ms_cnt to
            // DURATION_MS, so busy spans exactly DURATION_MS*TICKS_PER_MS cycles.
            if (prescale == PRE_LAST) begin
              prescale <= '0;
              if (ms_cnt == MS_LAST) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                wave     <= 1'b0;
                half_cnt <= '0;
                ms_cnt   <= '0;
              end else begin
                ms_cnt <= ms_cnt + 10'd1;
              end
            end else begin
              prescale <= prescale + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Mute gates the output combinationally so it takes effect immediately.
  assign sound_out = wave & (state == PLAY) & ~mute;

endmodule
